product_accumulator: RTL and testbench



---
 rtl/product_accumulator.sv | 146 ++++++++++++++
 tb/tb_product_accumulator.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Multiply-accumulate back end for the N-bit combinational multiplier. It
// takes a burst of LEN unsigned 2N-bit products over a valid/ready
// handshake, adds them into an ACC_W-bit accumulator, and offers the burst
// sum over a second valid/ready handshake.
//
// Burst flow: IDLE --start--> ACCUM --LEN transfers--> DONE --acc_ready--> IDLE
//
// Parameters
//   N      multiplier operand width; the product input is 2N bits wide
//   LEN    products per burst, legal range 1..255
//   ACC_W  accumulator width, must be >= 2N
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new burst; honoured only in IDLE
//   p_valid    p_in carries a valid product
//   p_ready    a product is accepted this cycle (ACCUM only)
//   p_in       unsigned product from the multiplier
//   acc_valid  burst result available (DONE only)
//   acc_ready  consumer takes the result
//   acc_out    accumulated sum, unsigned
//   cnt        products accepted in the current burst
//   ovf        sticky: a carry out of ACC_W occurred during this burst
//
// Configuration
//   PRODUCT_ACC_SAT_EN  defined   : on a carry the sum saturates at all-ones
//                       undefined : on a carry the sum wraps modulo 2^ACC_W
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int N     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [2*N-1:0]   p_in,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Count value held just before the final transfer of a burst.
  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             xfer;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  // One extra bit above the accumulator captures the carry of this addition.
  assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(p_in);
  assign carry = sum[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
  // Once saturated, every further addition carries again (or adds zero),
  // so the sum stays pinned at all-ones for the rest of the burst.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  // p_ready and acc_valid decode distinct states, so the input and output
  // handshakes can never complete in the same cycle.
  assign p_ready   = (state_q == ACCUM);
  assign acc_valid = (state_q == DONE);
  assign xfer      = p_valid && p_ready;

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        // No transfer in the start cycle: ACCUM is entered only at the edge.
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_d = acc_next;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | carry;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end

      DONE: begin
        if (acc_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out = acc_q;
  assign cnt     = cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Two instances share clock and reset: u_dut (N=4, LEN=4, ACC_W=10) and
// u_dut8 (N=4, LEN=8, ACC_W=10, used for the overflow burst). Expected burst
// results are pushed to a queue when the last product is driven and popped
// when acc_valid is seen.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

`ifdef PRODUCT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] acc;
    logic [7:0] cnt;
    logic       ovf;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start, p_valid, acc_ready;
  logic [7:0] p_in;
  logic       p_ready, acc_valid, ovf;
  logic [9:0] acc_out;
  logic [7:0] cnt;

  logic       b_start, b_p_valid, b_acc_ready;
  logic [7:0] b_p_in;
  logic       b_p_ready, b_acc_valid, b_ovf;
  logic [9:0] b_acc_out;
  logic [7:0] b_cnt;

  result_t    exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  product_accumulator #(.N(4), .LEN(4), .ACC_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p_valid(p_valid),
    .p_ready(p_ready), .p_in(p_in), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_out(acc_out), .cnt(cnt), .ovf(ovf)
  );

  product_accumulator #(.N(4), .LEN(8), .ACC_W(10)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .p_valid(b_p_valid),
    .p_ready(b_p_ready), .p_in(b_p_in), .acc_valid(b_acc_valid),
    .acc_ready(b_acc_ready), .acc_out(b_acc_out), .cnt(b_cnt), .ovf(b_ovf)
  );

  // Advance to just after the next rising edge; drive and sample there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference accumulator step.
  function automatic result_t model_add(input result_t r, input logic [7:0] p);
    logic [10:0] s;
    result_t     o;
    s     = {1'b0, r.acc} + {3'b000, p};
    o     = r;
    o.cnt = r.cnt + 8'd1;
    if (s[10]) begin
      o.ovf = 1'b1;
      o.acc = SAT ? 10'h3FF : s[9:0];
    end else begin
      o.acc = s[9:0];
    end
    return o;
  endfunction

  // Bounded wait for a result on the selected instance, then scoreboard pop.
  task automatic check_result(input bit wide, input string name);
    bit      seen = 1'b0;
    result_t e, got;
    for (int i = 0; i < 40; i++) begin
      if ((wide ? b_acc_valid : acc_valid) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!seen || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no result (acc_valid seen=%0b, queued=%0d)", name, seen, exp_q.size());
      return;
    end
    e   = exp_q.pop_front();
    got = wide ? result_t'{b_acc_out, b_cnt, b_ovf} : result_t'{acc_out, cnt, ovf};
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got acc=%0d cnt=%0d ovf=%0b, expected acc=%0d cnt=%0d ovf=%0b",
               name, got.acc, got.cnt, got.ovf, e.acc, e.cnt, e.ovf);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, want;
    got  = {acc_out, cnt, ovf, p_ready, acc_valid, b_acc_out, b_ovf, b_p_ready, b_acc_valid};
    want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", got, want);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  // Basic burst with p_valid/p_in active in the start cycle, then retention.
  task automatic test_basic();
    logic [7:0] prods[4] = '{8'd15, 8'd225, 8'd30, 8'd0};
    logic [9:0] run[4]   = '{10'd15, 10'd240, 10'd270, 10'd270};
    start = 1'b1; p_valid = 1'b1; p_in = 8'd9;
    tick();
    start = 1'b0;
    vectors++;
    if (cnt !== 8'd0 || acc_out !== 10'd0 || p_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_cycle: cnt=%0d acc=%0d p_ready=%0b, expected 0 0 1", cnt, acc_out, p_ready);
    end
    for (int i = 0; i < 4; i++) begin
      p_in = prods[i];
      if (i == 3) exp_q.push_back('{10'd270, 8'd4, 1'b0});
      tick();
      vectors++;
      if (acc_out !== run[i] || cnt !== 8'(i + 1) || acc_valid !== (i == 3)) begin
        miscompares++;
        $display("FAIL basic_step%0d: acc=%0d cnt=%0d acc_valid=%0b, expected %0d %0d %0b",
                 i, acc_out, cnt, acc_valid, run[i], i + 1, (i == 3));
      end
    end
    p_valid = 1'b0;
    check_result(1'b0, "basic_result");
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (acc_out !== 10'd270 || cnt !== 8'd4 || ovf !== 1'b0 || acc_valid !== 1'b0 || p_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL retention%0d: acc=%0d cnt=%0d ovf=%0b acc_valid=%0b p_ready=%0b, expected 270 4 0 0 0",
                 i, acc_out, cnt, ovf, acc_valid, p_ready);
      end
    end
  endtask

  // Input gaps, a start pulse in ACCUM and DONE, and a stalled consumer.
  task automatic test_backpressure();
    start = 1'b1;
    tick();
    start = 1'b0;
    p_valid = 1'b1; p_in = 8'd10;
    tick();
    p_valid = 1'b0; p_in = 8'd99;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (cnt !== 8'd1 || acc_out !== 10'd10) begin
        miscompares++;
        $display("FAIL gap_hold%0d: cnt=%0d acc=%0d, expected 1 10", i, cnt, acc_out);
      end
    end
    p_valid = 1'b1; p_in = 8'd20; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (cnt !== 8'd2 || acc_out !== 10'd30) begin
      miscompares++;
      $display("FAIL start_in_accum: cnt=%0d acc=%0d, expected 2 30", cnt, acc_out);
    end
    p_in = 8'd30;
    tick();
    p_in = 8'd40;
    exp_q.push_back('{10'd100, 8'd4, 1'b0});
    tick();
    p_valid = 1'b0;
    check_result(1'b0, "backpressure_result");
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      tick();
      vectors++;
      if (acc_valid !== 1'b1 || acc_out !== 10'd100 || cnt !== 8'd4 || p_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL done_hold%0d: acc_valid=%0b acc=%0d cnt=%0d p_ready=%0b, expected 1 100 4 0",
                 i, acc_valid, acc_out, cnt, p_ready);
      end
    end
    start = 1'b0;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    vectors++;
    if (acc_valid !== 1'b0 || p_ready !== 1'b0 || acc_out !== 10'd100) begin
      miscompares++;
      $display("FAIL done_release: acc_valid=%0b p_ready=%0b acc=%0d, expected 0 0 100", acc_valid, p_ready, acc_out);
    end
  endtask

  // Eight products of 225 on the LEN=8 instance: total 1800 exceeds 1023.
  task automatic test_overflow();
    result_t m = '0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_p_valid = 1'b1; b_p_in = 8'd225;
    for (int i = 0; i < 8; i++) begin
      m = model_add(m, 8'd225);
      if (i == 7) exp_q.push_back(m);
      tick();
      if (i == 3 || i == 4) begin
        vectors++;
        if (b_ovf !== (i == 4) || b_acc_out !== m.acc) begin
          miscompares++;
          $display("FAIL ovf_step%0d: ovf=%0b acc=%0d, expected %0b %0d", i, b_ovf, b_acc_out, (i == 4), m.acc);
        end
      end
    end
    b_p_valid = 1'b0;
    vectors++;
    if (b_acc_out !== (SAT ? 10'd1023 : 10'd776) || b_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_final: acc=%0d ovf=%0b, expected %0d 1", b_acc_out, b_ovf, SAT ? 1023 : 776);
    end
    check_result(1'b1, "ovf_result");
    b_acc_ready = 1'b1;
    tick();
    b_acc_ready = 1'b0;
  endtask

  // Three randomized bursts, each started in the first IDLE cycle.
  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      result_t m = '0;
      int      sent = 0;
      int      budget = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (p_ready !== 1'b1 || cnt !== 8'd0 || ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_start%0d: p_ready=%0b cnt=%0d ovf=%0b, expected 1 0 0", b, p_ready, cnt, ovf);
      end
      while (sent < 4 && budget < 100) begin
        logic accepted;
        p_valid = ($urandom_range(0, 3) != 0);
        p_in    = 8'($urandom_range(0, 255));
        accepted = p_valid && p_ready;
        if (accepted) begin
          m = model_add(m, p_in);
          sent++;
          if (sent == 4) exp_q.push_back(m);
        end
        tick();
        budget++;
      end
      p_valid = 1'b0;
      check_result(1'b0, "b2b_result");
      repeat ($urandom_range(0, 2)) tick();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      vectors++;
      if (acc_valid !== 1'b0 || acc_out !== m.acc) begin
        miscompares++;
        $display("FAIL b2b_release%0d: acc_valid=%0b acc=%0d, expected 0 %0d", b, acc_valid, acc_out, m.acc);
      end
    end
  endtask

  // Asynchronous reset between edges after two transfers.
  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    p_valid = 1'b1; p_in = 8'd100;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (acc_out !== 10'd0 || cnt !== 8'd0 || ovf !== 1'b0 || p_ready !== 1'b0 || acc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: acc=%0d cnt=%0d ovf=%0b p_ready=%0b acc_valid=%0b, expected all 0",
               acc_out, cnt, ovf, p_ready, acc_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (p_ready !== 1'b0 || cnt !== 8'd0 || acc_out !== 10'd0) begin
        miscompares++;
        $display("FAIL post_reset_idle%0d: p_ready=%0b cnt=%0d acc=%0d, expected 0 0 0", i, p_ready, cnt, acc_out);
      end
    end
    p_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (p_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_start: p_ready=%0b, expected 1", p_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; p_valid = 1'b0; p_in = '0; acc_ready = 1'b0;
    b_start = 1'b0; b_p_valid = 1'b0; b_p_in = '0; b_acc_ready = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
